// File: rtl/ltssm_pkg.sv
// ltssm_pkg: shared LTSSM state codes, FSM encoding and timeout defaults.
// Imported by the Detect/Polling front-end and its timer.
package ltssm_pkg;

  localparam logic [3:0] ST_DETECT = 4'd0;
  localparam logic [3:0] ST_POLL   = 4'd1;
  localparam logic [3:0] ST_CFG    = 4'd2;

  localparam logic [3:0] SS_D_QUIET  = 4'd0;
  localparam logic [3:0] SS_D_ACTIVE = 4'd1;
  localparam logic [3:0] SS_P_ACTIVE = 4'd0;
  localparam logic [3:0] SS_P_CFG    = 4'd1;
  localparam logic [3:0] SS_C_IDLE   = 4'd0;

  localparam int T_QUIET_DEF    = 12000;
  localparam int T_DET_ACT_DEF  = 12000;
  localparam int T_POLL_ACT_DEF = 24000;
  localparam int T_POLL_CFG_DEF = 48000;

  typedef enum logic [2:0] {
    S_D_QUIET,
    S_D_ACTIVE,
    S_P_ACTIVE,
    S_P_CFG,
    S_C_IDLE
  } ltssm_st_e;

  function automatic logic [7:0] ts_pack(input ltssm_st_e s);
    logic [7:0] r;
    unique case (s)
      S_D_QUIET:  r = {ST_DETECT, SS_D_QUIET};
      S_D_ACTIVE: r = {ST_DETECT, SS_D_ACTIVE};
      S_P_ACTIVE: r = {ST_POLL, SS_P_ACTIVE};
      S_P_CFG:    r = {ST_POLL, SS_P_CFG};
      S_C_IDLE:   r = {ST_CFG, SS_C_IDLE};
      default:    r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ltssm_detect_poll_if.sv
// ltssm_detect_poll_if: PHY-lane and TS-generator signals of the front-end.
// master = LTSSM side, slave = PHY lanes / TS generator side.
interface ltssm_detect_poll_if #(
  parameter int LANE_NUM = 4
);
  logic [LANE_NUM-1:0] elec_idle_break;
  logic [LANE_NUM-1:0] rx_det_seq_req;
  logic [LANE_NUM-1:0] rx_det_seq_ack;
  logic [LANE_NUM-1:0] rx_det_valid;
  logic [LANE_NUM-1:0] ts1_p2c;
  logic [LANE_NUM-1:0] ts2_p2c;
  logic                ts_sent;
  logic [7:0]          ts_info;
  logic                ts_update;
  logic                ts_stop;
  logic [5:0]          speed;
  logic [LANE_NUM-1:0] lane_active;
  logic                cfg_entry;

  modport master (
    input  elec_idle_break, rx_det_seq_ack, rx_det_valid,
    input  ts1_p2c, ts2_p2c, ts_sent,
    output rx_det_seq_req, ts_info, ts_update, ts_stop,
    output speed, lane_active, cfg_entry
  );

  modport slave (
    output elec_idle_break, rx_det_seq_ack, rx_det_valid,
    output ts1_p2c, ts2_p2c, ts_sent,
    input  rx_det_seq_req, ts_info, ts_update, ts_stop,
    input  speed, lane_active, cfg_entry
  );

endinterface

// File: rtl/ltssm_timer.sv
// ltssm_timer: loadable down counter, one expired pulse when it reaches 0.
// A load of 0 leaves the timer disarmed.
module ltssm_timer #(
  parameter int TIMER_W = 32
) (
  input  logic               clk,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] val_i,
  output logic               expired_o
);

  logic [TIMER_W-1:0] cnt_q;
  logic               armed_q;
  logic               exp_q;

  // count down while armed; pulse on the 1 -> 0 step
  always_ff @(posedge clk) begin
    if (load_i) begin
      cnt_q   <= val_i;
      armed_q <= (val_i != '0);
      exp_q   <= 1'b0;
    end else begin
      exp_q <= 1'b0;
      if (armed_q) begin
        cnt_q <= cnt_q - TIMER_W'(1);
        if (cnt_q == TIMER_W'(1)) begin
          armed_q <= 1'b0;
          exp_q   <= 1'b1;
        end
      end
    end
  end

  assign expired_o = exp_q;

endmodule

// File: rtl/ltssm_detect_poll.sv
// ltssm_detect_poll: Detect and Polling link-training front-end.
// Runs receiver detection, qualifies TS1/TS2 and hands off to Configuration.
module ltssm_detect_poll
  import ltssm_pkg::*;
#(
  parameter int         LANE_NUM   = 4,
  parameter int         TIMER_W    = 32,
  parameter int         T_QUIET    = T_QUIET_DEF,
  parameter int         T_DET_ACT  = T_DET_ACT_DEF,
  parameter int         T_POLL_ACT = T_POLL_ACT_DEF,
  parameter int         T_POLL_CFG = T_POLL_CFG_DEF,
  parameter int         TS1_TX_MIN = 1024,
  parameter int         RX_CNT     = 8,
  parameter int         TS2_TX_MIN = 16,
  parameter int         PARTIAL_EN = 1,
  parameter logic [5:0] SPEED_INIT = 6'b000001
) (
  input  logic              clk,
  input  logic              rst,
  ltssm_detect_poll_if.master bus
);

  localparam int RX_W   = $clog2(RX_CNT + 1);
  localparam int TX_MAX = (TS1_TX_MIN > TS2_TX_MIN) ? TS1_TX_MIN : TS2_TX_MIN;
  localparam int TX_W   = $clog2(TX_MAX + 1);

  ltssm_st_e st_q, st_d;

  logic [LANE_NUM-1:0] req_q;
  logic [LANE_NUM-1:0] det_q;
  logic [LANE_NUM-1:0] act_q, act_d;
  logic [LANE_NUM-1:0] lane_ok;
  logic [TX_W-1:0]     tx_q;
  logic                ts2_seen_q;
  logic                brk_q;
  logic [7:0]          ts_info_q;
  logic                ts_update_q;
  logic                ts_stop_q;
  logic                cfg_entry_q;

  logic                expired;
  logic                entry;
  logic                pcfg_entry;
  logic                all_ok;
  logic                tmr_load;
  logic [TIMER_W-1:0]  tmr_val;

  assign all_ok     = &lane_ok;
  assign entry      = (st_d != st_q);
  assign pcfg_entry = (st_q == S_P_ACTIVE) && (st_d == S_P_CFG);
  assign tmr_load   = rst || entry;

  // next substate, lane set and timer reload; exits win over expiry
  always_comb begin
    st_d    = st_q;
    act_d   = act_q;
    tmr_val = '0;
    unique case (st_q)
      S_D_QUIET: begin
        if (brk_q || expired) st_d = S_D_ACTIVE;
      end
      S_D_ACTIVE: begin
        if (req_q == '0) begin
          if (&det_q) begin
            st_d  = S_P_ACTIVE;
            act_d = '1;
          end else if ((PARTIAL_EN != 0) && (|det_q)) begin
            st_d  = S_P_ACTIVE;
            act_d = det_q;
          end else begin
            st_d = S_D_QUIET;
          end
        end else if (expired) begin
          st_d = S_D_QUIET;
        end
      end
      S_P_ACTIVE: begin
        if (all_ok && (tx_q >= TX_W'(TS1_TX_MIN))) st_d = S_P_CFG;
        else if (expired) st_d = S_D_QUIET;
      end
      S_P_CFG: begin
        if (all_ok && ts2_seen_q && (tx_q >= TX_W'(TS2_TX_MIN)))
          st_d = S_C_IDLE;
        else if (expired)
          st_d = S_D_QUIET;
      end
      S_C_IDLE: st_d = S_C_IDLE;
      default:  st_d = S_D_QUIET;
    endcase
    if (st_d == S_D_QUIET) act_d = '0;
    unique case (st_d)
      S_D_QUIET:  tmr_val = TIMER_W'(T_QUIET);
      S_D_ACTIVE: tmr_val = TIMER_W'(T_DET_ACT);
      S_P_ACTIVE: tmr_val = TIMER_W'(T_POLL_ACT);
      S_P_CFG:    tmr_val = TIMER_W'(T_POLL_CFG);
      default:    tmr_val = '0;
    endcase
    if (rst) tmr_val = TIMER_W'(T_QUIET);
  end

  ltssm_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clk       (clk),
    .load_i    (tmr_load),
    .val_i     (tmr_val),
    .expired_o (expired)
  );

  // state, detect handshake and registered TS-generator outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= S_D_QUIET;
      req_q       <= '0;
      det_q       <= '0;
      act_q       <= '0;
      brk_q       <= 1'b0;
      ts_info_q   <= 8'h00;
      ts_update_q <= 1'b0;
      ts_stop_q   <= 1'b1;
      cfg_entry_q <= 1'b0;
    end else begin
      st_q        <= st_d;
      act_q       <= act_d;
      brk_q       <= (st_q == S_D_QUIET) && (st_d == S_D_QUIET) &&
                     (|bus.elec_idle_break);
      ts_info_q   <= ts_pack(st_d);
      ts_stop_q   <= (st_d == S_D_QUIET) || (st_d == S_D_ACTIVE);
      ts_update_q <= entry && (st_d inside {S_P_ACTIVE, S_P_CFG, S_C_IDLE});
      cfg_entry_q <= entry && (st_d == S_C_IDLE);
      if (entry && (st_d == S_D_ACTIVE)) begin
        req_q <= '1;
        det_q <= '0;
      end else if (st_q == S_D_ACTIVE) begin
        if (st_d == S_D_QUIET) begin
          req_q <= '0;
        end else begin
          req_q <= req_q & ~bus.rx_det_seq_ack;
          det_q <= det_q |
                   (req_q & bus.rx_det_seq_ack & bus.rx_det_valid);
        end
      end
    end
  end

  // per-lane consecutive TS counters, saturating at RX_CNT
  for (genvar i = 0; i < LANE_NUM; i++) begin : g_lane
    logic [RX_W-1:0] cnt_q;

    // count TS1/TS2 in P_ACTIVE, TS2 runs with TS1 restart in P_CFG
    always_ff @(posedge clk) begin
      if (rst || (st_q == S_D_QUIET) || pcfg_entry) begin
        cnt_q <= '0;
      end else if (act_q[i]) begin
        if (st_q == S_P_ACTIVE) begin
          if ((bus.ts1_p2c[i] || bus.ts2_p2c[i]) &&
              (cnt_q != RX_W'(RX_CNT)))
            cnt_q <= cnt_q + RX_W'(1);
        end else if (st_q == S_P_CFG) begin
          if (bus.ts1_p2c[i])
            cnt_q <= '0;
          else if (bus.ts2_p2c[i] && (cnt_q != RX_W'(RX_CNT)))
            cnt_q <= cnt_q + RX_W'(1);
        end
      end
    end

    assign lane_ok[i] = !act_q[i] || (cnt_q == RX_W'(RX_CNT));
  end

  // transmitted-set counter; in P_CFG it starts after the first TS2
  always_ff @(posedge clk) begin
    if (rst || (st_q == S_D_QUIET) || pcfg_entry) begin
      tx_q       <= '0;
      ts2_seen_q <= 1'b0;
    end else if (st_q == S_P_ACTIVE) begin
      if (bus.ts_sent && (tx_q < TX_W'(TS1_TX_MIN)))
        tx_q <= tx_q + TX_W'(1);
    end else if (st_q == S_P_CFG) begin
      if (|(bus.ts2_p2c & act_q)) ts2_seen_q <= 1'b1;
      if (ts2_seen_q && bus.ts_sent && (tx_q < TX_W'(TS2_TX_MIN)))
        tx_q <= tx_q + TX_W'(1);
    end
  end

  assign bus.rx_det_seq_req = req_q;
  assign bus.ts_info        = ts_info_q;
  assign bus.ts_update      = ts_update_q;
  assign bus.ts_stop        = ts_stop_q;
  assign bus.speed          = SPEED_INIT;
  assign bus.lane_active    = act_q;
  assign bus.cfg_entry      = cfg_entry_q;

endmodule

// File: tb/tb_ltssm_detect_poll.sv
// tb_ltssm_detect_poll: directed + randomized checks of Detect/Polling.
// Two DUTs share stimulus: one with partial links enabled, one without.
module tb_ltssm_detect_poll;

  localparam int TQ  = 12000;
  localparam int TDA = 64;
  localparam int TPA = 3000;
  localparam int TPC = 400;
  localparam int TX1 = 1024;
  localparam int RXN = 8;
  localparam int TX2 = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] eib = '0, ack = '0, vld = '0, t1 = '0, t2 = '0;
  logic snt = 1'b0;
  int nvec = 0;
  int nmiss = 0;

  always #5 clk = ~clk;

  ltssm_detect_poll_if #(.LANE_NUM(4)) bus_a ();
  ltssm_detect_poll_if #(.LANE_NUM(4)) bus_b ();

  assign bus_a.elec_idle_break = eib;
  assign bus_a.rx_det_seq_ack  = ack;
  assign bus_a.rx_det_valid    = vld;
  assign bus_a.ts1_p2c         = t1;
  assign bus_a.ts2_p2c         = t2;
  assign bus_a.ts_sent         = snt;
  assign bus_b.elec_idle_break = eib;
  assign bus_b.rx_det_seq_ack  = ack;
  assign bus_b.rx_det_valid    = vld;
  assign bus_b.ts1_p2c         = t1;
  assign bus_b.ts2_p2c         = t2;
  assign bus_b.ts_sent         = snt;

  ltssm_detect_poll #(
    .LANE_NUM(4), .TIMER_W(32), .T_QUIET(TQ), .T_DET_ACT(TDA),
    .T_POLL_ACT(TPA), .T_POLL_CFG(TPC), .TS1_TX_MIN(TX1),
    .RX_CNT(RXN), .TS2_TX_MIN(TX2), .PARTIAL_EN(1),
    .SPEED_INIT(6'b000001)
  ) dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  ltssm_detect_poll #(
    .LANE_NUM(4), .TIMER_W(32), .T_QUIET(TQ), .T_DET_ACT(TDA),
    .T_POLL_ACT(TPA), .T_POLL_CFG(TPC), .TS1_TX_MIN(TX1),
    .RX_CNT(RXN), .TS2_TX_MIN(TX2), .PARTIAL_EN(0),
    .SPEED_INIT(6'b000001)
  ) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmiss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_info"}, bus_a.ts_info, 8'h00);
    chk({tag, "_upd"}, 8'(bus_a.ts_update), 8'h00);
    chk({tag, "_stop"}, 8'(bus_a.ts_stop), 8'h01);
    chk({tag, "_speed"}, 8'(bus_a.speed), 8'h01);
    chk({tag, "_act"}, 8'(bus_a.lane_active), 8'h00);
    chk({tag, "_req"}, 8'(bus_a.rx_det_seq_req), 8'h00);
    chk({tag, "_cfg"}, 8'(bus_a.cfg_entry), 8'h00);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    eib = '0; ack = '0; t1 = '0; t2 = '0; snt = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // reset, break out of Quiet, ack lanes in random order with valid v
  task automatic do_detect(input logic [3:0] v);
    int ord[4];
    logic [3:0] pend;
    logic [3:0] m;
    logic [7:0] ea, eb;
    logic [3:0] la, lb;
    do_reset();
    eib = 4'($urandom_range(1, 15));
    tick();
    eib = '0;
    chk("brk_wait", bus_a.ts_info, 8'h00);
    tick();
    chk("dact_info", bus_a.ts_info, 8'h01);
    chk("dact_req", 8'(bus_a.rx_det_seq_req), 8'h0f);
    for (int i = 0; i < 4; i++) ord[i] = i;
    for (int i = 3; i > 0; i--) begin
      int j;
      int t;
      j = $urandom_range(0, i);
      t = ord[i]; ord[i] = ord[j]; ord[j] = t;
    end
    pend = 4'hf;
    for (int k = 0; k < 4; k++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        vld = 4'($urandom);
        tick();
        chk("req_hold", 8'(bus_a.rx_det_seq_req), 8'(pend));
      end
      m = 4'(1 << ord[k]);
      ack = m;
      vld = (4'($urandom) & ~m) | (v & m);
      tick();
      ack = '0;
      vld = 4'($urandom);
      pend = pend & ~m;
      chk("req_drop", 8'(bus_a.rx_det_seq_req), 8'(pend));
    end
    tick();
    vld = '0;
    if (v == 4'hf) begin
      ea = 8'h10; la = 4'hf; eb = 8'h10; lb = 4'hf;
    end else if (v != 4'h0) begin
      ea = 8'h10; la = v; eb = 8'h00; lb = 4'h0;
    end else begin
      ea = 8'h00; la = 4'h0; eb = 8'h00; lb = 4'h0;
    end
    chk("det_info_a", bus_a.ts_info, ea);
    chk("det_act_a", 8'(bus_a.lane_active), 8'(la));
    chk("det_upd_a", 8'(bus_a.ts_update), 8'(ea == 8'h10));
    chk("det_stop_a", 8'(bus_a.ts_stop), 8'(ea == 8'h00));
    chk("det_info_b", bus_b.ts_info, eb);
    chk("det_act_b", 8'(bus_b.lane_active), 8'(lb));
  endtask

  // P_ACTIVE with a counting model; mode picks the TS/TX pattern
  task automatic poll_active(input int mode, input logic [3:0] act);
    int cnt[4];
    int tx;
    bit met;
    bit ok;
    logic [3:0] p1, p2;
    logic s;
    logic [7:0] exp;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    tx = 0;
    met = 1'b0;
    for (int c = 1; c <= TPA + 1; c++) begin
      p1 = '0; p2 = '0; s = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (mode == 0) begin
          p1[i] = ($urandom % 8) == 0;
          p2[i] = ($urandom % 16) == 0;
        end else if (mode == 1 || i < 3) begin
          p1[i] = 1'b1;
        end else if (mode == 2) begin
          p1[i] = (c <= 7);
        end else begin
          p1[i] = (c <= 7) || (c == TPA);
        end
      end
      if (mode == 0) s = ($urandom % 4) != 0;
      p1 = (p1 & act) | (4'($urandom) & ~act);
      p2 = (p2 & act) | (4'($urandom) & ~act);
      t1 = p1; t2 = p2; snt = s;
      tick();
      t1 = '0; t2 = '0; snt = 1'b0;
      exp = met ? 8'h11 : (c == TPA + 1) ? 8'h00 : 8'h10;
      for (int i = 0; i < 4; i++)
        if (act[i] && (p1[i] || p2[i]) && cnt[i] < RXN) cnt[i]++;
      if (s && tx < TX1) tx++;
      chk("pa_info", bus_a.ts_info, exp);
      chk("pa_upd", 8'(bus_a.ts_update), 8'(exp == 8'h11));
      if (exp != 8'h10) break;
      ok = (tx >= TX1);
      for (int i = 0; i < 4; i++)
        if (act[i] && cnt[i] < RXN) ok = 1'b0;
      met = ok;
    end
  endtask

  // P_CFG: lane 1 sees 5 TS2, later a TS1, then a fresh TS2 run
  task automatic poll_cfg(input logic [3:0] act);
    int cnt[4];
    int tx;
    bit seen, seen_prev, met, ok;
    logic [3:0] p1, p2;
    logic [7:0] exp;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    tx = 0;
    seen = 1'b0;
    met = 1'b0;
    for (int c = 1; c <= TPC + 1; c++) begin
      p1 = '0; p2 = '0;
      for (int i = 0; i < 4; i++) begin
        if (i == 1) begin
          p2[i] = (c <= 5) || (c >= 16);
          p1[i] = (c == 15);
        end else begin
          p2[i] = 1'b1;
        end
      end
      p1 = (p1 & act) | (4'($urandom) & ~act);
      p2 = (p2 & act) | (4'($urandom) & ~act);
      t1 = p1; t2 = p2; snt = 1'b1;
      tick();
      t1 = '0; t2 = '0; snt = 1'b0;
      exp = met ? 8'h20 : (c == TPC + 1) ? 8'h00 : 8'h11;
      seen_prev = seen;
      for (int i = 0; i < 4; i++) begin
        if (act[i]) begin
          if (p1[i]) cnt[i] = 0;
          else if (p2[i] && cnt[i] < RXN) cnt[i]++;
          if (p2[i]) seen = 1'b1;
        end
      end
      if (seen_prev && tx < TX2) tx++;
      chk("pc_info", bus_a.ts_info, exp);
      chk("pc_cfg", 8'(bus_a.cfg_entry), 8'(exp == 8'h20));
      chk("pc_upd", 8'(bus_a.ts_update), 8'(exp == 8'h20));
      if (exp != 8'h11) break;
      ok = (tx >= TX2);
      for (int i = 0; i < 4; i++)
        if (act[i] && cnt[i] < RXN) ok = 1'b0;
      met = ok;
    end
  endtask

  initial begin
    logic [3:0] pats[6];
    do_reset();
    chk_reset("rst");
    chk("rst_info_b", bus_b.ts_info, 8'h00);

    // Quiet timeout with no break, then Detect.Active timeout
    repeat (TQ) tick();
    chk("quiet_hold", bus_a.ts_info, 8'h00);
    chk("quiet_req0", 8'(bus_a.rx_det_seq_req), 8'h00);
    tick();
    chk("quiet_exp", bus_a.ts_info, 8'h01);
    chk("quiet_req", 8'(bus_a.rx_det_seq_req), 8'h0f);
    chk("quiet_stop", 8'(bus_a.ts_stop), 8'h01);
    repeat (TDA) tick();
    chk("dact_hold", bus_a.ts_info, 8'h01);
    tick();
    chk("dact_exp", bus_a.ts_info, 8'h00);
    chk("dact_clr", 8'(bus_a.rx_det_seq_req), 8'h00);

    // detect outcomes: full, partial, none, random subsets
    pats[0] = 4'hf;
    pats[1] = 4'b0011;
    pats[2] = 4'h0;
    for (int i = 3; i < 6; i++) pats[i] = 4'($urandom);
    for (int i = 0; i < 6; i++) do_detect(pats[i]);

    // partial link all the way to Configuration
    do_detect(4'b0011);
    poll_active(0, 4'b0011);
    poll_cfg(4'b0011);
    tick();
    chk("cfg_hold", bus_a.ts_info, 8'h20);
    chk("cfg_pulse", 8'(bus_a.cfg_entry), 8'h00);
    chk("cfg_stop", 8'(bus_a.ts_stop), 8'h00);
    chk("cfg_act", 8'(bus_a.lane_active), 8'h03);

    // full link into P_CFG, then reset mid-P_CFG
    do_detect(4'hf);
    poll_active(1, 4'hf);
    t2 = 4'hf; snt = 1'b1;
    tick();
    t2 = '0; snt = 1'b0;
    chk("pcfg_in", bus_a.ts_info, 8'h11);
    rst = 1'b1;
    tick();
    chk_reset("midrst");
    rst = 1'b0;

    // Polling.Active timeout: lane 3 gets only 7 TS1
    do_detect(4'hf);
    poll_active(2, 4'hf);
    chk("pto_info", bus_a.ts_info, 8'h00);
    chk("pto_stop", 8'(bus_a.ts_stop), 8'h01);
    chk("pto_act", 8'(bus_a.lane_active), 8'h00);

    // exit condition met on the expiry cycle
    do_detect(4'hf);
    poll_active(3, 4'hf);
    chk("tie_info", bus_a.ts_info, 8'h11);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end

endmodule

// File: doc/ltssm_detect_poll.md
# ltssm_detect_poll

Parametrised link-training front-end covering Detect and Polling for a `LANE_NUM`-wide link, ending at entry to Configuration.
- Sequences per-lane receiver detection, drives the TS generator through `ts_info`/`ts_update`/`ts_stop`, and qualifies per-lane TS1/TS2 reception and transmit counts against parametrised thresholds.
- Supports partial-width links (lane subset) and scaled timeouts for simulation.
- Sits between the PHY lane blocks (detect and TS receive) and the Configuration-state FSM.

## Interface
- `LANE_NUM`, 4: lane count, ≥1
- `TIMER_W`, 32: timer width
- `T_QUIET`, 12000: Detect.Quiet timeout, in clk cycles
- `T_DET_ACT`, 12000: Detect.Active timeout
- `T_POLL_ACT`, 24000: Polling.Active timeout
- `T_POLL_CFG`, 48000: Polling.Configuration timeout
- `TS1_TX_MIN`, 1024: TS sets to transmit in Polling.Active
- `RX_CNT`, 8: consecutive TS per lane required
- `TS2_TX_MIN`, 16: TS2 sets to transmit after the first TS2 is received
- `PARTIAL_EN`, 1: allow a lane-subset link
- `SPEED_INIT`, 6'b000001: advertised speed vector
- `clk` in 1: system clock
- `rst` in 1: reset; **synchronous, active-high**
- `elec_idle_break` in `LANE_NUM`: per-lane exit from electrical idle
- `rx_det_seq_req` out `LANE_NUM`: per-lane receiver-detect request
- `rx_det_seq_ack` in `LANE_NUM`: per-lane detect sequence done
- `rx_det_valid` in `LANE_NUM`: per-lane receiver present; sampled when the lane acks
- `ts1_p2c`, `ts2_p2c` in `LANE_NUM`: one-cycle pulse per TS1/TS2 received on a lane
- `ts_sent` in 1: one-cycle pulse per TS set transmitted on all lanes
- `ts_info` out 8: [7:4] state, [3:0] substate
- `ts_update` out 1: one-cycle pulse when `ts_info` changes
- `ts_stop` out 1: TS transmission halted
- `speed` out 6: advertised rates
- `lane_active` out `LANE_NUM`: lanes in the link
- `cfg_entry` out 1: one-cycle pulse on entry to Configuration

## Operation
- **States and substates:** DETECT=0 {QUIET=0, ACTIVE=1}; POLL=1 {ACTIVE=0, CFG=1}; CFG=2 {IDLE=0}. `ts_info`={state, substate}.
- **Substate entry:** the single down-timer loads that substate's timeout. Expiry means the timer is armed and reaches 0.
- **D_QUIET:**
  - Clear `lane_active` and all counters.
  - Go to D_ACTIVE on `|elec_idle_break` or expiry.
- **D_ACTIVE:**
  - On entry, set `rx_det_seq_req` to all ones.
  - Each bit clears on its ack; latch `rx_det_valid[i]` at that ack.
  - Once all requests are clear:
    - All latched valid → POLL, `lane_active` = all ones.
    - Nonzero subset with `PARTIAL_EN` → POLL, `lane_active` = subset.
    - Otherwise → D_QUIET.
  - Expiry before all acks → D_QUIET, requests cleared.
- **P_ACTIVE:**
  - Per active lane, a saturating count increments on a ts1 or ts2 pulse.
  - `ts_sent` increments a TX count, saturating at `TS1_TX_MIN`.
  - Go to P_CFG when TX count ≥ `TS1_TX_MIN` and every active lane count ≥ `RX_CNT`.
  - Expiry → D_QUIET.
- **P_CFG:**
  - On entry, clear the lane counts and the TX count.
  - A ts2 pulse increments the lane count; a ts1 pulse on that lane resets it to 0.
  - TX count runs only after the first ts2 on any active lane.
  - Go to CFG when all active lanes ≥ `RX_CNT` and TX count ≥ `TS2_TX_MIN`.
  - Expiry → D_QUIET.
- **CFG:** hold until `rst`.
- **Inactive lanes:** their TS inputs are ignored.
- **`ts_stop`:** 1 in DETECT, 0 in POLL and CFG.
- **`speed`:** constant `SPEED_INIT`.
- **Simultaneous events:** when an exit condition and expiry occur in the same cycle, the exit condition wins.

## Timing
- All outputs are registered.
- A transition decided at edge N updates state, `ts_info` and `ts_stop` at edge N+1.
- At edge N+1:
  - `ts_update` is high for exactly one cycle on every POLL/CFG entry.
  - `cfg_entry` pulses on CFG entry.
  - The timer loads on every substate entry.
- `rx_det_seq_req` asserts at the D_ACTIVE entry edge; a bit drops one cycle after its ack.
- A D_QUIET timeout of `T_QUIET` gives the exit decision `T_QUIET` cycles after entry.
- **Reset values:** DETECT/D_QUIET with the timer loaded with `T_QUIET`; `rx_det_seq_req`=0; `ts_info`=8'h00; `ts_update`=0; `ts_stop`=1; `speed`=`SPEED_INIT`; `lane_active`=0; `cfg_entry`=0.
- **Reset mid-operation:** `rst` in any state restores these values at the next edge.

## Structure
- **Package `ltssm_pkg`:** state and substate localparams, a `ts_info` pack function, and the timeout defaults.
- **Sub-module `ltssm_timer`:** `TIMER_W`-bit loadable down counter with `load`, `val` and an `expired` pulse. Per-lane counters are generate-loop logic in the top module.

## Test plan
- **Quiet timeout:** no break; D_ACTIVE after 12000 cycles; `rx_det_seq_req`=4'hF.
- **Full detect:** lane 2 breaks → D_ACTIVE; ack all with valid=4'hF → `ts_info`=8'h10, `ts_update` pulse, `lane_active`=4'hF, `ts_stop`=0.
- **Partial link:** valid=4'b0011, `PARTIAL_EN`=1 → `lane_active`=4'b0011; lanes 2–3 TS ignored. With `PARTIAL_EN`=0 → D_QUIET.
- **Polling to CFG:** 1024 `ts_sent`, 8 TS1 per lane → 8'h11. In P_CFG, a TS1 on lane 1 after 5 TS2 restarts its count. 8 TS2 per lane plus 16 TX → 8'h20, `cfg_entry` pulse.
- **Poll timeout:** only 7 TS1 on lane 3 → at 24000 cycles back to 8'h00, `ts_stop`=1. Exit and expiry in the same cycle → exit taken.
- **Reset mid-P_CFG:** all outputs at reset values at the next edge.
